// File: rtl/clefia_pkg.sv
// ---------------------------------------------------------------------------
// clefia_pkg
// Shared constants and types for the CLEFIA key-schedule constant generator:
//   - pair-function constants P and Q
//   - initial T values and pair counts per key length
//   - GF(2^16) step constant (T := T * x^-1 modulo 0x1a831)
//   - key_len encodings and the generator state enum
// No ports (package).
// ---------------------------------------------------------------------------
package clefia_pkg;

  localparam logic [15:0] CON_P     = 16'hb7e1;
  localparam logic [15:0] CON_Q     = 16'h243f;

  localparam logic [15:0] IV_128    = 16'h428a;
  localparam logic [15:0] IV_192    = 16'h7137;
  localparam logic [15:0] IV_256    = 16'hb5c0;

  // Feedback term applied after the right shift when T[0] was set.
  localparam logic [15:0] GF_STEP_C = 16'hd418;

  // Number of CON pairs per key length.
  localparam logic [5:0]  L_128     = 6'd30;
  localparam logic [5:0]  L_192     = 6'd42;
  localparam logic [5:0]  L_256     = 6'd46;

  localparam logic [1:0]  KEY_128   = 2'b00;
  localparam logic [1:0]  KEY_192   = 2'b01;
  localparam logic [1:0]  KEY_256   = 2'b10;
  localparam logic [1:0]  KEY_ILL   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Rotate a 16-bit word left by one bit.
  function automatic logic [15:0] rotl16_1(input logic [15:0] x);
    return {x[14:0], x[15]};
  endfunction

  // Rotate a 16-bit word left by eight bits (byte swap).
  function automatic logic [15:0] rotl16_8(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

endpackage

// File: rtl/clefia_con_gen_if.sv
// ---------------------------------------------------------------------------
// clefia_con_gen_if
// Valid/ready stream carrying CON pairs from the generator to the key schedule.
//   con_valid  : master -> slave, beat present
//   con_ready  : slave  -> master, beat accepted when both are high
//   con        : CON_W bits, lowest pair index in the most-significant 64 bits
//   con_idx    : pair index of the most-significant pair of the beat
//   con_last   : beat holds the final pair of the sequence
// ---------------------------------------------------------------------------
interface clefia_con_gen_if #(
  parameter int CON_W = 64
);
  logic             con_valid;
  logic             con_ready;
  logic [CON_W-1:0] con;
  logic [5:0]       con_idx;
  logic             con_last;

  modport master (
    output con_valid,
    output con,
    output con_idx,
    output con_last,
    input  con_ready
  );

  modport slave (
    input  con_valid,
    input  con,
    input  con_idx,
    input  con_last,
    output con_ready
  );
endinterface

// File: rtl/clefia_con_step.sv
// ---------------------------------------------------------------------------
// clefia_con_step
// Purely combinational: from the current state T produce the CON pair
// {CON(2i), CON(2i+1)} and the next state T * x^-1 in GF(2^16).
//   t_i      in  16  current T
//   pair_o   out 64  {T^P, rotl1(~T), ~T^Q, rotl8(T)}
//   t_next_o out 16  stepped T
// ---------------------------------------------------------------------------
module clefia_con_step
  import clefia_pkg::*;
(
  input  logic [15:0] t_i,
  output logic [63:0] pair_o,
  output logic [15:0] t_next_o
);

  logic [15:0] t_inv_s;

  assign t_inv_s = ~t_i;
  assign pair_o  = {t_i ^ CON_P, rotl16_1(t_inv_s), t_inv_s ^ CON_Q, rotl16_8(t_i)};

  // Division by x: shift right, folding the reduction polynomial back in when
  // the dropped bit was set.
  always_comb begin
    t_next_o = {1'b0, t_i[15:1]};
    if (t_i[0]) begin
      t_next_o = {1'b0, t_i[15:1]} ^ GF_STEP_C;
    end else begin
      t_next_o = {1'b0, t_i[15:1]};
    end
  end

endmodule

// File: rtl/clefia_con_gen.sv
// ---------------------------------------------------------------------------
// clefia_con_gen
// Sequential CLEFIA key-schedule constant generator (128/192/256-bit keys).
// Streams CON(2i)||CON(2i+1) pairs, PAIRS_PER_BEAT (1 or 2) per beat.
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle request, starts (or restarts) a sequence
//   key_len    00=128, 01=192, 10=256, 11=illegal; sampled with start
//   con_if     valid/ready stream of pairs (master side)
//   busy       generator is in RUN
//   done       one-cycle pulse after the last beat is accepted
//   err        one-cycle pulse after start with key_len = 11
// con is derived from the T register only, so no input reaches it
// combinationally.
// ---------------------------------------------------------------------------
module clefia_con_gen
  import clefia_pkg::*;
#(
  parameter int PAIRS_PER_BEAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             key_len,
  clefia_con_gen_if.master       con_if,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int         CON_W   = 64 * PAIRS_PER_BEAT;
  localparam logic [5:0] PPB_INC = 6'(PAIRS_PER_BEAT);

  state_e      state_q, state_d;
  logic [15:0] t_q,     t_d;
  logic [5:0]  idx_q,   idx_d;
  logic [5:0]  len_q,   len_d;
  logic        done_q,  done_d;
  logic        err_q,   err_d;

  logic [15:0] iv_s;
  logic [5:0]  len_sel_s;
  logic        run_s;
  logic        last_s;
  logic        accept_s;
  logic [CON_W-1:0] con_s;

  logic [15:0] t_chain_s [0:PAIRS_PER_BEAT];
  logic [63:0] pair_s    [0:PAIRS_PER_BEAT-1];

  // Chain of step stages: stage k yields pair k of the beat and T advanced k+1 times.
  assign t_chain_s[0] = t_q;
  for (genvar k = 0; k < PAIRS_PER_BEAT; k++) begin : g_step
    clefia_con_step u_step (
      .t_i      (t_chain_s[k]),
      .pair_o   (pair_s[k]),
      .t_next_o (t_chain_s[k+1])
    );
  end

  // Pack pairs with the lowest index in the most-significant 64 bits.
  always_comb begin
    con_s = '0;
    for (int k = 0; k < PAIRS_PER_BEAT; k++) begin
      con_s[CON_W-1-64*k -: 64] = pair_s[k];
    end
  end

  // Initial T and pair count selected by the requested key length.
  always_comb begin
    iv_s      = IV_128;
    len_sel_s = L_128;
    case (key_len)
      KEY_128: begin iv_s = IV_128; len_sel_s = L_128; end
      KEY_192: begin iv_s = IV_192; len_sel_s = L_192; end
      KEY_256: begin iv_s = IV_256; len_sel_s = L_256; end
      default: begin iv_s = IV_128; len_sel_s = L_128; end
    endcase
  end

  assign run_s    = (state_q == ST_RUN);
  assign last_s   = run_s && ((idx_q + PPB_INC) == len_q);
  assign accept_s = run_s && con_if.con_ready;

  // Next-state logic. start outranks an accept in RUN: a legal start reloads
  // (dropping the current beat and any done), an illegal one aborts to IDLE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    idx_d   = idx_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (key_len == KEY_ILL) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            t_d     = iv_s;
            idx_d   = 6'd0;
            len_d   = len_sel_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start) begin
          if (key_len == KEY_ILL) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
            t_d     = iv_s;
            idx_d   = 6'd0;
            len_d   = len_sel_s;
          end
        end else if (accept_s) begin
          t_d   = t_chain_s[PAIRS_PER_BEAT];
          idx_d = idx_q + PPB_INC;
          if (last_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, T, index, length and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= 16'h0000;
      idx_q   <= 6'd0;
      len_q   <= 6'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign con_if.con_valid = run_s;
  assign con_if.con       = con_s;
  assign con_if.con_idx   = idx_q;
  assign con_if.con_last  = last_s;
  assign busy             = run_s;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_clefia_con_gen.sv
module tb_clefia_con_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  logic [1:0] key1, key2;
  logic       busy1, done1, err1, busy2, done2, err2;

  clefia_con_gen_if #(.CON_W(64))  if1 ();
  clefia_con_gen_if #(.CON_W(128)) if2 ();

  clefia_con_gen #(.PAIRS_PER_BEAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_len(key1),
    .con_if(if1), .busy(busy1), .done(done1), .err(err1)
  );

  clefia_con_gen #(.PAIRS_PER_BEAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key2),
    .con_if(if2), .busy(busy2), .done(done2), .err(err2)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] got_q[$];
  logic [63:0] ref_q[$];

  typedef struct {
    logic [1:0]  k;
    int          idx;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the constant generator.
  function automatic logic [15:0] m_step(input logic [15:0] t);
    logic [15:0] s;
    s = t >> 1;
    if (t[0]) s = s ^ 16'hd418;
    return s;
  endfunction

  function automatic logic [63:0] m_pair(input logic [15:0] t);
    logic [15:0] n;
    n = ~t;
    return {t ^ 16'hb7e1, n[14:0], n[15], n ^ 16'h243f, t[7:0], t[15:8]};
  endfunction

  function automatic logic [15:0] m_iv(input logic [1:0] k);
    case (k)
      2'b01:   return 16'h7137;
      2'b10:   return 16'hb5c0;
      default: return 16'h428a;
    endcase
  endfunction

  function automatic int m_len(input logic [1:0] k);
    case (k)
      2'b01:   return 42;
      2'b10:   return 46;
      default: return 30;
    endcase
  endfunction

  // Pulse start for one cycle; called on a falling edge, returns on the next.
  task automatic kick1(input logic [1:0] k);
    start1 = 1'b1;
    key1   = k;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // Consume a whole sequence from dut1 which is presenting pair 0 of key k.
  task automatic collect1(input logic [1:0] k, input bit stall, input string tag);
    logic [15:0] t;
    logic [63:0] hcon;
    logic [5:0]  hidx;
    int          len;
    int          n;
    int          cyc;
    bit          fin;
    bit          held;
    t = m_iv(k); len = m_len(k); n = 0; cyc = 0; fin = 1'b0; held = 1'b0;
    hcon = '0; hidx = '0;
    got_q.delete();
    while (!fin && cyc < 2000) begin
      cyc++;
      if (held) begin
        chk({tag, " stall_con"}, 128'(if1.con), 128'(hcon));
        chk({tag, " stall_idx"}, 128'(if1.con_idx), 128'(hidx));
      end
      if (if1.con_valid) begin
        ready1_set(stall);
        if (if1.con_ready) begin
          chk({tag, " con"}, 128'(if1.con), 128'(m_pair(t)));
          chk({tag, " idx"}, 128'(if1.con_idx), 128'(n));
          chk({tag, " last"}, 128'(if1.con_last), 128'(n == len - 1));
          got_q.push_back(if1.con);
          t = m_step(t);
          n++;
          held = 1'b0;
          if (if1.con_last || n > len) fin = 1'b1;
        end else begin
          held = 1'b1;
          hcon = if1.con;
          hidx = if1.con_idx;
        end
      end else begin
        chk({tag, " valid"}, 128'(if1.con_valid), 128'(1));
        fin = 1'b1;
      end
      @(negedge clk);
    end
    if (!fin) begin
      n_checks++; n_err++;
      $display("FAIL %s timeout: got %0d beats expected %0d", tag, n, len);
    end
    if1.con_ready = 1'b1;
    chk({tag, " beats"}, 128'(n), 128'(len));
    chk({tag, " done"}, 128'(done1), 128'(1));
    chk({tag, " valid_after"}, 128'(if1.con_valid), 128'(0));
    chk({tag, " busy_after"}, 128'(busy1), 128'(0));
    @(negedge clk);
    chk({tag, " done_pulse"}, 128'(done1), 128'(0));
  endtask

  task automatic ready1_set(input bit stall);
    if (stall) if1.con_ready = ($urandom_range(0, 2) != 0);
    else       if1.con_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] t;
    int          n;
    bit          fin;

    tbl[0] = '{2'b00, 0,  64'hf56b7aeb_994a8a42};
    tbl[1] = '{2'b00, 1,  64'h96a4bd75_fa854521};
    tbl[2] = '{2'b00, 11, 64'h88cc81a5_e4ed2d3f};
    tbl[3] = '{2'b01, 0,  64'hc6d61d91_aaf73771};
    tbl[4] = '{2'b10, 0,  64'h0221947e_6e00c0b5};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; key1 = 2'b00; key2 = 2'b00;
    if1.con_ready = 1'b1; if2.con_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst valid", 128'(if1.con_valid), 128'(0));
    chk("rst busy",  128'(busy1), 128'(0));
    chk("rst done",  128'(done1), 128'(0));
    chk("rst err",   128'(err1), 128'(0));
    chk("rst idx",   128'(if1.con_idx), 128'(0));
    chk("rst valid2", 128'(if2.con_valid), 128'(0));

    // Directed vectors from the table, each on a full unstalled sequence.
    for (int i = 0; i < 5; i++) begin
      kick1(tbl[i].k);
      collect1(tbl[i].k, 1'b0, "tbl");
      if (got_q.size() > tbl[i].idx) chk("tbl vec", 128'(got_q[tbl[i].idx]), 128'(tbl[i].exp));
      else chk("tbl size", 128'(got_q.size()), 128'(tbl[i].idx + 1));
      if (i == 0) ref_q = got_q;
    end

    // Random backpressure must reproduce the unstalled stream exactly.
    kick1(2'b00);
    collect1(2'b00, 1'b1, "stall");
    chk("stall count", 128'(got_q.size()), 128'(ref_q.size()));
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      chk("stall seq", 128'(got_q[i]), 128'(ref_q[i]));

    // Restart with 192 while idx 5 of a 128-bit run is being accepted.
    kick1(2'b00);
    if1.con_ready = 1'b1;
    n = 0;
    while (if1.con_idx != 6'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("restart reach5", 128'(if1.con_idx), 128'(5));
    kick1(2'b01);
    chk("restart nodone", 128'(done1), 128'(0));
    chk("restart pair0", 128'(if1.con), 128'(64'hc6d61d91_aaf73771));
    collect1(2'b01, 1'b0, "restart");

    // Illegal key length from IDLE.
    start1 = 1'b1; key1 = 2'b11;
    @(negedge clk);
    start1 = 1'b0;
    chk("err idle pulse", 128'(err1), 128'(1));
    chk("err idle valid", 128'(if1.con_valid), 128'(0));
    chk("err idle busy",  128'(busy1), 128'(0));
    @(negedge clk);
    chk("err idle clear", 128'(err1), 128'(0));

    // Illegal key length mid-run aborts to IDLE.
    kick1(2'b00);
    @(negedge clk); @(negedge clk);
    kick1(2'b11);
    chk("err run pulse", 128'(err1), 128'(1));
    chk("err run valid", 128'(if1.con_valid), 128'(0));
    chk("err run busy",  128'(busy1), 128'(0));
    chk("err run done",  128'(done1), 128'(0));
    @(negedge clk);

    // Reset mid-run, then a fresh sequence behaves as from power-up.
    kick1(2'b10);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst valid", 128'(if1.con_valid), 128'(0));
    chk("midrst busy",  128'(busy1), 128'(0));
    chk("midrst idx",   128'(if1.con_idx), 128'(0));
    chk("midrst done",  128'(done1), 128'(0));
    kick1(2'b00);
    collect1(2'b00, 1'b0, "post_rst");

    // Two pairs per beat, 128-bit key.
    start2 = 1'b1; key2 = 2'b00; if2.con_ready = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("ppb2 beat0", if2.con, 128'hf56b7aeb_994a8a42_96a4bd75_fa854521);
    t = 16'h428a; n = 0; fin = 1'b0;
    while (!fin && n < 20) begin
      chk("ppb2 valid", 128'(if2.con_valid), 128'(1));
      chk("ppb2 con", if2.con, {m_pair(t), m_pair(m_step(t))});
      chk("ppb2 idx", 128'(if2.con_idx), 128'(2 * n));
      chk("ppb2 last", 128'(if2.con_last), 128'(n == 14));
      if (if2.con_last || !if2.con_valid) fin = 1'b1;
      t = m_step(m_step(t));
      n++;
      @(negedge clk);
    end
    chk("ppb2 beats", 128'(n), 128'(15));
    chk("ppb2 done", 128'(done2), 128'(1));
    chk("ppb2 valid_after", 128'(if2.con_valid), 128'(0));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
